// File: rtl/lcd_pkg.sv
// Shared types and constants for the HD44780 write engine: FSM states,
// status word layout, default cycle timings and the slow-command opcodes.
package lcd_pkg;

  typedef enum logic [3:0] {
    PWR_WAIT,
    INIT_SETUP,
    INIT_E,
    INIT_WAIT,
    IDLE,
    SETUP,
    E_HI,
    GAP,
    SETTLE
  } lcd_state_t;

  localparam int ST_BUSY   = 0;
  localparam int ST_INIT   = 1;
  localparam int ST_OVF    = 2;
  localparam int ST_CNT_LO = 3;
  localparam int ST_CNT_HI = 5;

  localparam int ENTRY_W   = 9;
  localparam int FIFO_AW   = 2;
  localparam int FIFO_CW   = 3;

  localparam int DEF_T_POWERUP = 750_000;
  localparam int DEF_T_INIT1   = 205_000;
  localparam int DEF_T_INIT2   = 5_000;
  localparam int DEF_T_SETUP   = 2;
  localparam int DEF_T_E_HIGH  = 12;
  localparam int DEF_T_GAP     = 50;
  localparam int DEF_T_CMD     = 2_000;
  localparam int DEF_T_CLEAR   = 82_000;

  localparam logic [7:0] OP_CLEAR    = 8'h01;
  localparam logic [7:0] OP_HOME     = 8'h02;
  localparam logic [7:0] OP_HOME_ALT = 8'h03;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  // Clear and return-home need the long settle; everything else is fast.
  function automatic logic is_slow_cmd(input logic [ENTRY_W-1:0] x);
    return !x[8] && ((x[7:0] == OP_CLEAR) || (x[7:0] == OP_HOME) ||
                     (x[7:0] == OP_HOME_ALT));
  endfunction

endpackage

// File: rtl/lcd_write_engine_fifo.sv
// 4-entry command FIFO holding {rs, byte}; head is the oldest entry.
module lcd_cmd_fifo
  import lcd_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               push,
  input  logic               pop,
  input  logic [ENTRY_W-1:0] din,
  output logic [ENTRY_W-1:0] head,
  output logic [FIFO_CW-1:0] count
);

  logic [ENTRY_W-1:0] mem [4];
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic               do_push, do_pop;

  assign do_pop  = pop && (count != '0);
  assign do_push = push && ((count != FIFO_CW'(4)) || do_pop);
  assign head    = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      count <= count + {2'b0, do_push} - {2'b0, do_pop};
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= din;
  end

endmodule

// File: rtl/lcd_write_engine.sv
// HD44780 4-bit write engine: power-up init, then FIFO-fed bytes sent as two
// nibbles with exact setup / enable / settle cycle counts.
module lcd_write_engine
  import lcd_pkg::*;
#(
  parameter int CLK_HZ    = 50_000_000,
  parameter int T_POWERUP = DEF_T_POWERUP,
  parameter int T_INIT1   = DEF_T_INIT1,
  parameter int T_INIT2   = DEF_T_INIT2,
  parameter int T_SETUP   = DEF_T_SETUP,
  parameter int T_E_HIGH  = DEF_T_E_HIGH,
  parameter int T_GAP     = DEF_T_GAP,
  parameter int T_CMD     = DEF_T_CMD,
  parameter int T_CLEAR   = DEF_T_CLEAR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        read,
  input  logic        write,
  input  logic [15:0] in_bus,
  output logic [15:0] out_bus,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_e,
  output logic [3:0]  lcd_d
);

  localparam int T_MAX = max2(max2(max2(T_POWERUP, T_INIT1), max2(T_INIT2, T_SETUP)),
                              max2(max2(T_E_HIGH, T_GAP), max2(T_CMD, T_CLEAR)));
  localparam int CW = $clog2(T_MAX) + 1;

  localparam logic [CW-1:0] L_PWR   = CW'(T_POWERUP - 1);
  localparam logic [CW-1:0] L_INIT1 = CW'(T_INIT1 - 1);
  localparam logic [CW-1:0] L_INIT2 = CW'(T_INIT2 - 1);
  localparam logic [CW-1:0] L_SETUP = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] L_EHI   = CW'(T_E_HIGH - 1);
  localparam logic [CW-1:0] L_GAP   = CW'(T_GAP - 1);
  localparam logic [CW-1:0] L_CMD   = CW'(T_CMD - 1);
  localparam logic [CW-1:0] L_CLEAR = CW'(T_CLEAR - 1);

  lcd_state_t         state, state_n;
  logic [CW-1:0]      cnt, cnt_load;
  logic               load, init_drive, second;
  logic [3:0]         init_nib;
  logic [1:0]         init_idx;
  logic [ENTRY_W-1:0] cur, head;
  logic [FIFO_CW-1:0] count, count_n;
  logic               pop, accept, init_done, ovf, busy;
  logic               unused_bits;

  // Strobes are single-cycle: write enqueues in_bus[8:0] when there is room
  // (a same-cycle pop frees a slot), otherwise it is dropped and flags
  // overflow; read only clears the overflow flag.
  assign pop     = (state == IDLE) && (count != '0);
  assign accept  = write && ((count != FIFO_CW'(4)) || pop);
  assign count_n = count + {2'b0, accept} - {2'b0, pop};

  assign lcd_rw      = 1'b0;
  assign unused_bits = (^in_bus[15:9]) ^ (CLK_HZ > 0);

  lcd_cmd_fifo u_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (accept),
    .pop   (pop),
    .din   (in_bus[8:0]),
    .head  (head),
    .count (count)
  );

  always_comb begin
    state_n    = state;
    load       = 1'b0;
    cnt_load   = '0;
    init_drive = 1'b0;
    init_nib   = 4'h3;
    case (state)
      PWR_WAIT: if (cnt == '0) begin
        state_n = INIT_SETUP; load = 1'b1; cnt_load = L_SETUP; init_drive = 1'b1;
      end
      INIT_SETUP: if (cnt == '0) begin
        state_n = INIT_E; load = 1'b1; cnt_load = L_EHI;
      end
      INIT_E: if (cnt == '0) begin
        state_n  = INIT_WAIT;
        load     = 1'b1;
        cnt_load = (init_idx == 2'd0) ? L_INIT1 : (init_idx == 2'd1) ? L_INIT2 : L_CMD;
      end
      INIT_WAIT: if (cnt == '0) begin
        if (init_idx == 2'd3) begin
          state_n = IDLE;
        end else begin
          state_n = INIT_SETUP; load = 1'b1; cnt_load = L_SETUP; init_drive = 1'b1;
          init_nib = (init_idx == 2'd2) ? 4'h2 : 4'h3;
        end
      end
      IDLE: if (pop) begin
        state_n = SETUP; load = 1'b1; cnt_load = L_SETUP;
      end
      SETUP: if (cnt == '0) begin
        state_n = E_HI; load = 1'b1; cnt_load = L_EHI;
      end
      E_HI: if (cnt == '0) begin
        load = 1'b1;
        if (second) begin
          state_n  = SETTLE;
          cnt_load = is_slow_cmd(cur) ? L_CLEAR : L_CMD;
        end else begin
          state_n  = GAP;
          cnt_load = L_GAP;
        end
      end
      GAP: if (cnt == '0) begin
        state_n = SETUP; load = 1'b1; cnt_load = L_SETUP;
      end
      SETTLE: if (cnt == '0) state_n = IDLE;
      default: begin
        state_n = PWR_WAIT; load = 1'b1; cnt_load = L_PWR;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= PWR_WAIT;
      cnt       <= L_PWR;
      init_idx  <= '0;
      cur       <= '0;
      second    <= 1'b0;
      init_done <= 1'b0;
      ovf       <= 1'b0;
      busy      <= 1'b0;
      lcd_e     <= 1'b0;
      lcd_rs    <= 1'b0;
      lcd_d     <= '0;
    end else begin
      state <= state_n;
      if (load) cnt <= cnt_load;
      else if (cnt != '0) cnt <= cnt - 1'b1;
      lcd_e <= (state_n == INIT_E) || (state_n == E_HI);
      busy  <= (state_n != IDLE) || (count_n != '0);
      if (state_n == IDLE) init_done <= 1'b1;
      if (write && !accept) ovf <= 1'b1;
      else if (read) ovf <= 1'b0;
      if (init_drive) begin
        lcd_rs <= 1'b0;
        lcd_d  <= init_nib;
        if (state == INIT_WAIT) init_idx <= init_idx + 1'b1;
      end
      if (pop) begin
        cur    <= head;
        lcd_rs <= head[8];
        lcd_d  <= head[7:4];
        second <= 1'b0;
      end
      // Low nibble changes one edge after lcd_e fell, never on the falling edge.
      if (state == GAP) begin
        lcd_d  <= cur[3:0];
        second <= 1'b1;
      end
    end
  end

  always_comb begin
    out_bus                      = '0;
    out_bus[ST_BUSY]             = busy;
    out_bus[ST_INIT]             = init_done;
    out_bus[ST_OVF]              = ovf;
    out_bus[ST_CNT_HI:ST_CNT_LO] = count;
  end

endmodule

// File: tb/tb_lcd_write_engine.sv
// Bench for lcd_write_engine: transaction-level model predicts every lcd_e
// pulse (time, rs, nibble) and the status word on each cycle.
module tb_lcd_write_engine;

  localparam int TP = 20, TI1 = 10, TI2 = 5, TS = 2, TE = 3, TG = 4, TC = 8, TCL = 30;

  logic        clk = 1'b0;
  logic        rst_n, read, write;
  logic [15:0] in_bus;
  logic [15:0] out_bus;
  logic        lcd_rs, lcd_rw, lcd_e;
  logic [3:0]  lcd_d;

  int checks = 0;
  int errors = 0;

  int         e_cnt;
  int         m_free;
  int         m_init_end;
  logic       m_ovf;
  logic [8:0] m_fifo[$];
  logic [36:0] exp_q[$];

  always #5 clk = ~clk;

  lcd_write_engine #(
    .CLK_HZ(50_000_000), .T_POWERUP(TP), .T_INIT1(TI1), .T_INIT2(TI2), .T_SETUP(TS),
    .T_E_HIGH(TE), .T_GAP(TG), .T_CMD(TC), .T_CLEAR(TCL)
  ) dut (
    .clk(clk), .rst_n(rst_n), .read(read), .write(write), .in_bus(in_bus),
    .out_bus(out_bus), .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_d(lcd_d)
  );

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d got=%h exp=%h", tag, e_cnt, got, exp);
    end
  endtask

  function automatic int settle_of(input logic [8:0] b);
    return (!b[8] && b[7:0] >= 8'd1 && b[7:0] <= 8'd3) ? TCL : TC;
  endfunction

  task automatic push_pulse(input int rise, input logic rs, input logic [3:0] d);
    exp_q.push_back({32'(rise), rs, d});
  endtask

  // Init: first nibble driven after TP cycles, then pulse + wait per nibble.
  task automatic model_reset();
    int t, w;
    e_cnt = 0;
    m_ovf = 1'b0;
    m_fifo.delete();
    exp_q.delete();
    t = TP;
    for (int i = 0; i < 4; i++) begin
      push_pulse(t + TS, 1'b0, (i == 3) ? 4'h2 : 4'h3);
      w = (i == 0) ? TI1 : (i == 1) ? TI2 : TC;
      t = t + TS + TE + w;
    end
    m_free     = t;
    m_init_end = t;
  endtask

  task automatic model_edge();
    logic [8:0] b;
    logic       ovf_set;
    ovf_set = 1'b0;
    if (m_fifo.size() != 0 && e_cnt >= m_free + 1) begin
      b = m_fifo.pop_front();
      push_pulse(e_cnt + TS, b[8], b[7:4]);
      push_pulse(e_cnt + 2*TS + TE + TG, b[8], b[3:0]);
      m_free = e_cnt + 2*TS + 2*TE + TG + settle_of(b);
    end
    if (write) begin
      if (m_fifo.size() < 4) m_fifo.push_back(in_bus[8:0]);
      else ovf_set = 1'b1;
    end
    if (ovf_set) m_ovf = 1'b1;
    else if (read) m_ovf = 1'b0;
  endtask

  task automatic check_cycle();
    logic [36:0] p;
    int          rise;
    logic        exp_e, bsy;
    logic [15:0] exp_bus;
    exp_e = 1'b0;
    if (exp_q.size() != 0) begin
      p    = exp_q[0];
      rise = int'(p[36:5]);
      if (e_cnt >= rise - TS) chk("lcd_pins", {11'b0, lcd_rs, lcd_d}, {11'b0, p[4:0]});
      exp_e = (e_cnt >= rise) && (e_cnt < rise + TE);
      if (e_cnt >= rise + TE - 1) void'(exp_q.pop_front());
    end
    chk("lcd_e", {15'b0, lcd_e}, {15'b0, exp_e});
    bsy     = (e_cnt < m_free) || (m_fifo.size() != 0);
    exp_bus = {10'b0, 3'(m_fifo.size()), m_ovf, (e_cnt >= m_init_end), bsy};
    chk("out_bus", out_bus, exp_bus);
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) begin
      e_cnt++;
      model_edge();
    end
    #1;
    if (rst_n) check_cycle();
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic send(input logic [15:0] v);
    write  = 1'b1;
    in_bus = v;
    tick();
    write  = 1'b0;
  endtask

  task automatic release_reset();
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic check_reset_values(input string tag);
    chk({tag, "_bus"}, out_bus, 16'h0000);
    chk({tag, "_pins"}, {9'b0, lcd_rw, lcd_e, lcd_rs, lcd_d}, 16'h0000);
  endtask

  initial begin
    int n;
    rst_n  = 1'b0;
    read   = 1'b0;
    write  = 1'b0;
    in_bus = '0;
    e_cnt  = 0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_values("reset");
    release_reset();

    // Power-up sequence with no traffic.
    run(75);
    chk("init_status", out_bus, 16'h0002);

    // Data byte, rs=1.
    send(16'h0141);
    run(30);
    chk("after_141", out_bus, 16'h0002);

    // Clear followed by a data byte: long settle in between.
    send(16'h0001);
    send(16'h0130);
    run(80);
    chk("after_clear", out_bus, 16'h0002);

    // Reset while lcd_e is high.
    send(16'h01A5);
    n = 0;
    while (lcd_e !== 1'b1 && n < 20) begin
      tick();
      n++;
    end
    chk("e_seen", {15'b0, lcd_e}, 16'h0001);
    rst_n = 1'b0;
    #1;
    check_reset_values("midreset");
    repeat (2) @(posedge clk);
    release_reset();

    // Six writes during init: four queued, overflow set.
    for (int i = 0; i < 6; i++) send(16'h0100 | 16'(i * 17));
    chk("ovf_full", {12'b0, out_bus[5:2]}, 16'h0009);
    read = 1'b1;
    tick();
    read = 1'b0;
    chk("ovf_cleared", {15'b0, out_bus[2]}, 16'h0000);

    // Write with FIFO full on the very edge of the first pop.
    n = 0;
    while (e_cnt < m_free && n < 200) begin
      tick();
      n++;
    end
    send(16'h0155);
    chk("full_pop", {12'b0, out_bus[5:2]}, 16'h0008);

    // Random traffic.
    for (int c = 0; c < 1500; c++) begin
      write  = ($urandom_range(0, 11) == 0);
      read   = ($urandom_range(0, 7) == 0);
      in_bus = 16'($urandom);
      if ($urandom_range(0, 3) == 0) in_bus[7:0] = 8'($urandom_range(1, 3));
      tick();
    end
    write = 1'b0;
    read  = 1'b0;

    n = 0;
    while ((exp_q.size() != 0 || m_fifo.size() != 0 || e_cnt < m_free) && n < 600) begin
      tick();
      n++;
    end
    checks++;
    assert (n < 600) else begin
      errors++;
      $error("FAIL drain_timeout got=%0d exp<600", n);
    end
    read = 1'b1;
    tick();
    read = 1'b0;
    chk("final_status", out_bus, 16'h0002);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lcd_write_engine.md
# lcd_write_engine

Downstream LCD stage behind the I/O bridge's LCD address slot. It accepts 9-bit LCD transfers (RS plus byte) as bus writes into a 4-entry FIFO and runs the HD44780 power-up sequence. It splits each transfer into two 4-bit nibbles and drives the character LCD pins with cycle-exact setup, enable-pulse and settle delays. It also returns a status word on the bus read path so software can poll instead of counting delays.

## Interface
- CLK_HZ, 50_000_000, clock frequency; documentation only, all delays are the cycle parameters below
- T_POWERUP, 750_000, cycles after reset before the first init nibble (15 ms)
- T_INIT1, 205_000, wait after init nibble 1 (4.1 ms)
- T_INIT2, 5_000, wait after init nibble 2 (100 µs)
- T_SETUP, 2, lcd_rs/lcd_d stable before lcd_e rises
- T_E_HIGH, 12, lcd_e high width
- T_GAP, 50, lcd_e low between the high and low nibble of one byte
- T_CMD, 2_000, settle after a byte or after init nibbles 3 and 4 (40 µs)
- T_CLEAR, 82_000, settle after clear/home (1.64 ms)
- clk  in  1  system clock; all logic on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- read  in  1  bus read strobe for this slot; clears the overflow flag
- write  in  1  bus write strobe for this slot; enqueues in_bus[8:0]
- in_bus  in  16  [8]=RS, [7:0]=byte; [15:9] ignored
- out_bus  out  16  status: [0] busy, [1] init_done, [2] overflow, [5:3] fifo count (0–4), [15:6]=0
- lcd_rs  out  1  register select
- lcd_rw  out  1  tied 0 (write-only)
- lcd_e  out  1  enable strobe
- lcd_d  out  4  data nibble, maps to LCD D7..D4

## Operation
- Reset values: lcd_e=0, lcd_rs=0, lcd_rw=0, lcd_d=0, FIFO empty, overflow=0, init_done=0, state=PWR_WAIT.
- States: PWR_WAIT, INIT_SETUP, INIT_E, INIT_WAIT, IDLE, SETUP, E_HI, GAP, SETTLE.
- Init: PWR_WAIT runs for T_POWERUP cycles. Then four nibbles are sent with rs=0: 0x3 (wait T_INIT1), 0x3 (wait T_INIT2), 0x3 (wait T_CMD), 0x2 (wait T_CMD). Each nibble uses the same SETUP/E pulse shape as data. init_done is set on entry to IDLE and stays set until reset.
- IDLE with FIFO non-empty: pop the entry and drive lcd_rs and the high nibble, then SETUP (T_SETUP cycles) → E_HI (T_E_HIGH cycles) → GAP (T_GAP cycles). In GAP, lcd_d takes the low nibble. Then SETUP → E_HI again → SETTLE → IDLE.
- SETTLE length is T_CLEAR when rs=0 and byte is 0x01, 0x02 or 0x03. Otherwise it is T_CMD.
- FIFO write rules:
  - A write is accepted when count<4, or when count==4 and a pop occurs in the same cycle.
  - Otherwise the write is dropped and overflow is set.
  - Writes during init are queued.
- Overflow is sticky. A read strobe clears it. If a read and a new overflow occur in the same cycle, set wins.
- busy = (state≠IDLE) or count≠0.
- out_bus is combinational from registered status. It is driven continuously; the bridge muxes it.
- A single down-counter serves every delay. Its width is clog2 of the largest timing parameter plus 1. The counter loads N−1 on state entry and the state exits when the counter reaches 0.

## Timing
- A write sampled at edge k is visible in count after edge k.
- From IDLE with an empty FIFO, the pop and pin update happen at edge k+1.
- lcd_e rises at edge k+1+T_SETUP and falls T_E_HIGH edges later.
- Byte occupancy from pop to next IDLE: 2·T_SETUP + 2·T_E_HIGH + T_GAP + settle.
- lcd_d and lcd_rs change only while lcd_e=0, never on the same edge as an lcd_e transition.
- Reset asserted mid-operation immediately forces all outputs to their reset values (lcd_e falls asynchronously), empties the FIFO and restarts the full init sequence.

## Structure
- Package lcd_pkg holds:
  - state enum
  - status bit indices (ST_BUSY=0, ST_INIT=1, ST_OVF=2, ST_CNT=5:3)
  - default timing constants
  - clear/home opcode constants
- Sub-module lcd_cmd_fifo: 4×9-bit synchronous FIFO with push/pop/count, async active-low reset.

## Test plan
Benches override the timing parameters to: T_POWERUP=20, T_INIT1=10, T_INIT2=5, T_SETUP=2, T_E_HIGH=3, T_GAP=4, T_CMD=8, T_CLEAR=30.
- Release rst_n, no writes → four lcd_e pulses, 3 cycles wide, with lcd_d=3,3,3,2 and rs=0. Pulse spacing follows the waits 10/5/8/8. out_bus=0x0002 afterwards.
- After init, write 0x141 → lcd_rs=1, lcd_d=4 then 1, two pulses separated by 4 low cycles. busy clears 8 cycles after the second pulse falls.
- Write 0x001 then 0x130 → second byte's first lcd_e rises no earlier than 30 cycles after the clear's low-nibble pulse falls.
- Six back-to-back writes during init → count=4, overflow=1 (out_bus[5:2]=4'b1001). Exactly the first four bytes are emitted. A read clears overflow to 0.
- Write with FIFO full in the same cycle as a pop → accepted, count stays 4, overflow stays 0.
- rst_n low while lcd_e=1 → lcd_e=0 in the same cycle, out_bus=0x0000, FIFO empty. The init sequence restarts after release.
